// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input in clk cycles.
// Also flags a stuck line and accumulator saturation. SYNC_STAGES must be >= 2.
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             meas_valid,
  output logic             meas_ovf,
  output logic             stuck,
  output logic             stuck_level
);

  // state  | meaning
  // S_IDLE | not armed; waiting for a rising edge
  // S_HIGH | armed, input high; period and high time accumulating
  // S_LOW  | armed, input low; period accumulating, high time frozen
  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_per_acc;
  logic [CNT_W-1:0]       r_hi_acc;
  logic                   r_ovf_acc;
  logic [CNT_W-1:0]       r_idle_left;
  logic [CNT_W-1:0]       r_period_cnt;
  logic [CNT_W-1:0]       r_high_cnt;
  logic                   r_meas_valid;
  logic                   r_meas_ovf;
  logic                   r_stuck;
  logic                   r_stuck_level;

  logic             w_s;
  logic             w_rise;
  logic             w_fall;
  logic             w_edge;
  logic             w_per_max;
  logic             w_hi_max;
  logic [CNT_W-1:0] w_per_next;
  logic [CNT_W-1:0] w_hi_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
      r_prev <= w_s;
    end
  end

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_prev;
  assign w_fall = ~w_s & r_prev;
  assign w_edge = w_rise | w_fall;

  // Saturating increments: accumulators stick at all-ones instead of wrapping.
  assign w_per_max  = &r_per_acc;
  assign w_hi_max   = &r_hi_acc;
  assign w_per_next = w_per_max ? r_per_acc : r_per_acc + ONE;
  assign w_hi_next  = w_hi_max  ? r_hi_acc  : r_hi_acc + ONE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_per_acc     <= '0;
      r_hi_acc      <= '0;
      r_ovf_acc     <= 1'b0;
      r_idle_left   <= TO_LOAD;
      r_period_cnt  <= '0;
      r_high_cnt    <= '0;
      r_meas_valid  <= 1'b0;
      r_meas_ovf    <= 1'b0;
      r_stuck       <= 1'b0;
      r_stuck_level <= 1'b0;
    end else begin
      r_meas_valid <= 1'b0;
      if (!enable) begin
        r_state       <= S_IDLE;
        r_per_acc     <= '0;
        r_hi_acc      <= '0;
        r_ovf_acc     <= 1'b0;
        r_idle_left   <= TO_LOAD;
        r_stuck       <= 1'b0;
        r_stuck_level <= 1'b0;
      end else if (w_edge) begin
        r_idle_left <= TO_LOAD;
        r_stuck     <= 1'b0;
        case (r_state)
          S_IDLE: begin
            if (w_rise) begin
              r_per_acc <= ONE;
              r_hi_acc  <= ONE;
              r_ovf_acc <= 1'b0;
              r_state   <= S_HIGH;
            end
          end
          S_HIGH: begin
            if (w_fall) begin
              r_per_acc <= w_per_next;
              if (w_per_max) r_ovf_acc <= 1'b1;
              r_state <= S_LOW;
            end
          end
          S_LOW: begin
            if (w_rise) begin
              r_period_cnt <= r_per_acc;
              r_high_cnt   <= r_hi_acc;
              r_meas_ovf   <= r_ovf_acc;
              r_meas_valid <= 1'b1;
              r_per_acc    <= ONE;
              r_hi_acc     <= ONE;
              r_ovf_acc    <= 1'b0;
              r_state      <= S_HIGH;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (r_idle_left == '0 && !r_stuck) begin
        // Dead line: drop the partial measurement and wait for a fresh rise.
        r_stuck       <= 1'b1;
        r_stuck_level <= w_s;
        r_state       <= S_IDLE;
        r_per_acc     <= '0;
        r_hi_acc      <= '0;
        r_ovf_acc     <= 1'b0;
      end else begin
        if (r_idle_left != '0) r_idle_left <= r_idle_left - ONE;
        case (r_state)
          S_HIGH: begin
            r_per_acc <= w_per_next;
            r_hi_acc  <= w_hi_next;
            if (w_per_max || w_hi_max) r_ovf_acc <= 1'b1;
          end
          S_LOW: begin
            r_per_acc <= w_per_next;
            if (w_per_max) r_ovf_acc <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign period_cnt  = r_period_cnt;
  assign high_cnt    = r_high_cnt;
  assign meas_valid  = r_meas_valid;
  assign meas_ovf    = r_meas_ovf;
  assign stuck       = r_stuck;
  assign stuck_level = r_stuck_level;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: random PWM waveforms against a rise-to-rise reference model.
// A second instance (CNT_W=8, 3 sync stages, TIMEOUT=255) covers saturation.
module tb_pwm_capture;
  localparam int SYNC  = 2;
  localparam int TO    = 1024;
  localparam int SYNC8 = 3;
  localparam int TO8   = 255;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic enable = 1'b0;
  logic pwm_in = 1'b0;

  logic [15:0] period_cnt, high_cnt;
  logic        meas_valid, meas_ovf, stuck, stuck_level;
  logic [7:0]  period_cnt8, high_cnt8;
  logic        meas_valid8, meas_ovf8, stuck8, stuck_level8;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic stuck_q = 1'b0;

  int tr_idx[$];
  bit tr_lvl[$];
  int m_cyc[$], m_per[$], m_hi[$];
  bit m_ovf[$];
  int m8_cyc[$], m8_per[$], m8_hi[$];
  bit m8_ovf[$];
  int e_cyc[$], e_per[$], e_hi[$];
  bit e_ovf[$];
  int st_rise_q[$], st_fall_q[$];
  bit st_lvl_q[$];

  always #5 clk = ~clk;

  pwm_capture #(.CNT_W(16), .SYNC_STAGES(SYNC), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pwm_in(pwm_in),
    .period_cnt(period_cnt), .high_cnt(high_cnt), .meas_valid(meas_valid),
    .meas_ovf(meas_ovf), .stuck(stuck), .stuck_level(stuck_level));

  pwm_capture #(.CNT_W(8), .SYNC_STAGES(SYNC8), .TIMEOUT(TO8)) dut8 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pwm_in(pwm_in),
    .period_cnt(period_cnt8), .high_cnt(high_cnt8), .meas_valid(meas_valid8),
    .meas_ovf(meas_ovf8), .stuck(stuck8), .stuck_level(stuck_level8));

  // Event log: cyc is the index of the posedge just taken.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    #1;
    if (meas_valid) begin
      m_cyc.push_back(cyc); m_per.push_back(int'(period_cnt));
      m_hi.push_back(int'(high_cnt)); m_ovf.push_back(meas_ovf);
    end
    if (meas_valid8) begin
      m8_cyc.push_back(cyc); m8_per.push_back(int'(period_cnt8));
      m8_hi.push_back(int'(high_cnt8)); m8_ovf.push_back(meas_ovf8);
    end
    if (stuck && !stuck_q) begin st_rise_q.push_back(cyc); st_lvl_q.push_back(stuck_level); end
    if (!stuck && stuck_q) st_fall_q.push_back(cyc);
    stuck_q <= stuck;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    tr_idx.delete(); tr_lvl.delete();
    m_cyc.delete(); m_per.delete(); m_hi.delete(); m_ovf.delete();
    m8_cyc.delete(); m8_per.delete(); m8_hi.delete(); m8_ovf.delete();
    st_rise_q.delete(); st_fall_q.delete(); st_lvl_q.delete();
  endtask

  task automatic fresh_start();
    @(negedge clk); enable = 1'b0; pwm_in = 1'b0;
    repeat (SYNC8 + 3) @(negedge clk);
    enable = 1'b1;
    clear_logs();
  endtask

  // The value set here is sampled at posedge number cyc+1.
  task automatic drive(input bit lvl, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (lvl != pwm_in) begin tr_idx.push_back(cyc + 1); tr_lvl.push_back(lvl); end
      pwm_in = lvl;
    end
  endtask

  task automatic pwm_period(input int per, input int hi);
    drive(1'b1, hi);
    drive(1'b0, per - hi);
  endtask

  // Reference: every rise after an armed rise closes a measurement whose period is
  // the rise-to-rise distance and high time the rise-to-fall distance, clipped.
  task automatic model_expect(input int sync, input int cw);
    int last_rise, last_fall, p, h, maxv;
    maxv = (1 << cw) - 1; last_rise = -1; last_fall = -1;
    e_cyc.delete(); e_per.delete(); e_hi.delete(); e_ovf.delete();
    foreach (tr_idx[i]) begin
      if (tr_lvl[i]) begin
        if (last_rise >= 0 && last_fall > last_rise) begin
          p = tr_idx[i] - last_rise;
          h = last_fall - last_rise;
          e_cyc.push_back(tr_idx[i] + sync);
          e_per.push_back(p > maxv ? maxv : p);
          e_hi.push_back(h > maxv ? maxv : h);
          e_ovf.push_back(p > maxv);
        end
        last_rise = tr_idx[i];
      end else begin
        last_fall = tr_idx[i];
      end
    end
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({meas_valid, meas_ovf, stuck, stuck_level} !== 4'b0) begin
      fails++; $display("FAIL reset_flags got %b exp 0000", {meas_valid, meas_ovf, stuck, stuck_level});
    end
    tests++;
    if (period_cnt !== 16'd0 || high_cnt !== 16'd0) begin
      fails++; $display("FAIL reset_counts got per=%0d hi=%0d exp 0/0", period_cnt, high_cnt);
    end
    tests++;
    if (period_cnt8 !== 8'd0 || meas_valid8 !== 1'b0) begin
      fails++; $display("FAIL reset_dut8 got per=%0d valid=%b exp 0/0", period_cnt8, meas_valid8);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    fresh_start();
    drive(1'b0, 10);
    repeat (5) pwm_period(100, 30);
    drive(1'b1, 5);
    drive(1'b0, 10);
    model_expect(SYNC, 16);
    tests++;
    if (m_cyc.size() !== e_cyc.size() || e_cyc.size() !== 5) begin
      fails++; $display("FAIL basic_count got %0d exp %0d", m_cyc.size(), e_cyc.size());
    end
    for (int i = 0; i < e_cyc.size() && i < m_cyc.size(); i++) begin
      tests++;
      if (m_cyc[i] !== e_cyc[i] || m_per[i] !== 100 || m_hi[i] !== 30 || m_ovf[i] !== 1'b0) begin
        fails++;
        $display("FAIL basic_meas[%0d] got cyc=%0d per=%0d hi=%0d ovf=%0d exp cyc=%0d per=100 hi=30 ovf=0",
                 i, m_cyc[i], m_per[i], m_hi[i], m_ovf[i], e_cyc[i]);
      end
    end
    tests++;
    if (period_cnt !== 16'd100 || high_cnt !== 16'd30 || meas_valid !== 1'b0) begin
      fails++; $display("FAIL basic_hold got per=%0d hi=%0d valid=%b exp 100/30/0", period_cnt, high_cnt, meas_valid);
    end
  endtask

  task automatic test_duty_sweep();
    int duties[3] = '{1, 50, 99};
    fresh_start();
    drive(1'b0, 10);
    foreach (duties[d]) repeat (2) pwm_period(100, duties[d]);
    drive(1'b1, 5);
    drive(1'b0, 10);
    model_expect(SYNC, 16);
    tests++;
    if (m_cyc.size() !== e_cyc.size()) begin
      fails++; $display("FAIL sweep_count got %0d exp %0d", m_cyc.size(), e_cyc.size());
    end
    for (int i = 0; i < e_cyc.size() && i < m_cyc.size(); i++) begin
      tests++;
      if (m_cyc[i] !== e_cyc[i] || m_per[i] !== e_per[i] || m_hi[i] !== e_hi[i] || m_ovf[i] !== e_ovf[i]) begin
        fails++;
        $display("FAIL sweep_meas[%0d] got cyc=%0d per=%0d hi=%0d ovf=%0d exp cyc=%0d per=%0d hi=%0d ovf=%0d",
                 i, m_cyc[i], m_per[i], m_hi[i], m_ovf[i], e_cyc[i], e_per[i], e_hi[i], e_ovf[i]);
      end
    end
    tests++;
    if (st_rise_q.size() !== 0) begin
      fails++; $display("FAIL sweep_stuck got %0d stuck events exp 0", st_rise_q.size());
    end
  endtask

  task automatic test_random();
    int per, hi;
    fresh_start();
    drive(1'b0, 10);
    repeat (10) begin
      per = $urandom_range(400, 2);
      hi  = $urandom_range(per - 1, 1);
      pwm_period(per, hi);
    end
    drive(1'b1, 5);
    drive(1'b0, 10);
    model_expect(SYNC, 16);
    tests++;
    if (m_cyc.size() !== e_cyc.size()) begin
      fails++; $display("FAIL random_count got %0d exp %0d", m_cyc.size(), e_cyc.size());
    end
    for (int i = 0; i < e_cyc.size() && i < m_cyc.size(); i++) begin
      tests++;
      if (m_cyc[i] !== e_cyc[i] || m_per[i] !== e_per[i] || m_hi[i] !== e_hi[i] || m_ovf[i] !== e_ovf[i]) begin
        fails++;
        $display("FAIL random_meas[%0d] got cyc=%0d per=%0d hi=%0d ovf=%0d exp cyc=%0d per=%0d hi=%0d ovf=%0d",
                 i, m_cyc[i], m_per[i], m_hi[i], m_ovf[i], e_cyc[i], e_per[i], e_hi[i], e_ovf[i]);
      end
    end
  endtask

  task automatic test_stuck(input bit lvl);
    int last, first;
    fresh_start();
    drive(1'b0, 10);
    repeat (lvl ? 2 : 3) pwm_period($urandom_range(200, 60), $urandom_range(50, 10));
    if (lvl) drive(1'b1, TO + 20); else drive(1'b0, TO + 20);
    last = tr_idx[$];
    model_expect(SYNC, 16);
    tests++;
    if (m_cyc.size() !== e_cyc.size() || e_cyc.size() !== 2) begin
      fails++; $display("FAIL stuck%0d_meas_count got %0d exp %0d", lvl, m_cyc.size(), e_cyc.size());
    end
    tests++;
    if (st_rise_q.size() !== 1 || st_rise_q[0] !== last + SYNC + TO) begin
      fails++; $display("FAIL stuck%0d_time got n=%0d cyc=%0d exp cyc=%0d", lvl, st_rise_q.size(),
                        st_rise_q.size() > 0 ? st_rise_q[0] : -1, last + SYNC + TO);
    end
    tests++;
    if (stuck !== 1'b1 || stuck_level !== lvl) begin
      fails++; $display("FAIL stuck%0d_level got stuck=%b level=%b exp 1/%b", lvl, stuck, stuck_level, lvl);
    end
    clear_logs();
    if (lvl) drive(1'b0, 30);
    else drive(1'b0, 5);
    repeat (lvl ? 2 : 3) pwm_period($urandom_range(200, 60), $urandom_range(50, 10));
    drive(1'b0, 10);
    first = tr_idx[0];
    model_expect(SYNC, 16);
    tests++;
    if (st_fall_q.size() !== 1 || st_fall_q[0] !== first + SYNC) begin
      fails++; $display("FAIL stuck%0d_clear got n=%0d cyc=%0d exp cyc=%0d", lvl, st_fall_q.size(),
                        st_fall_q.size() > 0 ? st_fall_q[0] : -1, first + SYNC);
    end
    tests++;
    if (m_cyc.size() !== e_cyc.size()) begin
      fails++; $display("FAIL stuck%0d_restore_count got %0d exp %0d", lvl, m_cyc.size(), e_cyc.size());
    end
    for (int i = 0; i < e_cyc.size() && i < m_cyc.size(); i++) begin
      tests++;
      if (m_cyc[i] !== e_cyc[i] || m_per[i] !== e_per[i] || m_hi[i] !== e_hi[i] || m_ovf[i] !== e_ovf[i]) begin
        fails++;
        $display("FAIL stuck%0d_restore[%0d] got cyc=%0d per=%0d hi=%0d exp cyc=%0d per=%0d hi=%0d",
                 lvl, i, m_cyc[i], m_per[i], m_hi[i], e_cyc[i], e_per[i], e_hi[i]);
      end
    end
  endtask

  task automatic test_saturation();
    int pers[6] = '{300, 300, 255, 256, 40, 300};
    int his[6]  = '{100, 100, 100, 100, 10, 100};
    fresh_start();
    drive(1'b0, 10);
    foreach (pers[k]) pwm_period(pers[k], his[k]);
    drive(1'b1, 5);
    drive(1'b0, 10);
    model_expect(SYNC8, 8);
    tests++;
    if (m8_cyc.size() !== e_cyc.size()) begin
      fails++; $display("FAIL sat8_count got %0d exp %0d", m8_cyc.size(), e_cyc.size());
    end
    for (int i = 0; i < e_cyc.size() && i < m8_cyc.size(); i++) begin
      tests++;
      if (m8_cyc[i] !== e_cyc[i] || m8_per[i] !== e_per[i] || m8_hi[i] !== e_hi[i] || m8_ovf[i] !== e_ovf[i]) begin
        fails++;
        $display("FAIL sat8_meas[%0d] got cyc=%0d per=%0d hi=%0d ovf=%0d exp cyc=%0d per=%0d hi=%0d ovf=%0d",
                 i, m8_cyc[i], m8_per[i], m8_hi[i], m8_ovf[i], e_cyc[i], e_per[i], e_hi[i], e_ovf[i]);
      end
    end
    if (m8_cyc.size() > 0) begin
      tests++;
      if (m8_per[0] !== 255 || m8_hi[0] !== 100 || m8_ovf[0] !== 1'b1) begin
        fails++; $display("FAIL sat8_first got per=%0d hi=%0d ovf=%0d exp 255/100/1", m8_per[0], m8_hi[0], m8_ovf[0]);
      end
    end
    model_expect(SYNC, 16);
    tests++;
    if (m_cyc.size() !== e_cyc.size()) begin
      fails++; $display("FAIL sat16_count got %0d exp %0d", m_cyc.size(), e_cyc.size());
    end
    for (int i = 0; i < e_cyc.size() && i < m_cyc.size(); i++) begin
      tests++;
      if (m_cyc[i] !== e_cyc[i] || m_per[i] !== e_per[i] || m_hi[i] !== e_hi[i] || m_ovf[i] !== e_ovf[i]) begin
        fails++;
        $display("FAIL sat16_meas[%0d] got cyc=%0d per=%0d hi=%0d ovf=%0d exp cyc=%0d per=%0d hi=%0d ovf=%0d",
                 i, m_cyc[i], m_per[i], m_hi[i], m_ovf[i], e_cyc[i], e_per[i], e_hi[i], e_ovf[i]);
      end
    end
  endtask

  task automatic test_enable_drop();
    int h, n_before, last_per, last_hi;
    fresh_start();
    drive(1'b0, 10);
    repeat (3) begin
      h = $urandom_range(60, 10);
      pwm_period(h + $urandom_range(120, 70), h);
    end
    drive(1'b1, $urandom_range(60, 10));
    drive(1'b0, 20);
    model_expect(SYNC, 16);
    n_before = e_cyc.size();
    last_per = (n_before > 0) ? e_per[n_before-1] : 0;
    last_hi  = (n_before > 0) ? e_hi[n_before-1] : 0;
    tests++;
    if (m_cyc.size() !== n_before || n_before !== 3) begin
      fails++; $display("FAIL en_pre_count got %0d exp %0d", m_cyc.size(), n_before);
    end
    @(negedge clk); enable = 1'b0;
    drive(1'b0, 10);
    tests++;
    if (m_cyc.size() !== n_before) begin
      fails++; $display("FAIL en_low_valid got %0d meas exp %0d", m_cyc.size(), n_before);
    end
    tests++;
    if (int'(period_cnt) !== last_per || int'(high_cnt) !== last_hi || stuck !== 1'b0) begin
      fails++; $display("FAIL en_low_hold got per=%0d hi=%0d stuck=%b exp %0d/%0d/0",
                        period_cnt, high_cnt, stuck, last_per, last_hi);
    end
    @(negedge clk); enable = 1'b1;
    clear_logs();
    drive(1'b0, 30);
    repeat (3) pwm_period($urandom_range(200, 40), $urandom_range(30, 5));
    drive(1'b1, 5);
    drive(1'b0, 10);
    model_expect(SYNC, 16);
    tests++;
    if (m_cyc.size() !== e_cyc.size()) begin
      fails++; $display("FAIL en_post_count got %0d exp %0d", m_cyc.size(), e_cyc.size());
    end
    for (int i = 0; i < e_cyc.size() && i < m_cyc.size(); i++) begin
      tests++;
      if (m_cyc[i] !== e_cyc[i] || m_per[i] !== e_per[i] || m_hi[i] !== e_hi[i] || m_ovf[i] !== e_ovf[i]) begin
        fails++;
        $display("FAIL en_post_meas[%0d] got cyc=%0d per=%0d hi=%0d exp cyc=%0d per=%0d hi=%0d",
                 i, m_cyc[i], m_per[i], m_hi[i], e_cyc[i], e_per[i], e_hi[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    fresh_start();
    drive(1'b0, 10);
    repeat (2) pwm_period(90, 40);
    drive(1'b1, 40);
    tests++;
    if (period_cnt !== 16'd90 || high_cnt !== 16'd40) begin
      fails++; $display("FAIL rst_pre got per=%0d hi=%0d exp 90/40", period_cnt, high_cnt);
    end
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    tests++;
    if (period_cnt !== 16'd0 || high_cnt !== 16'd0 || {meas_valid, meas_ovf, stuck, stuck_level} !== 4'b0) begin
      fails++; $display("FAIL rst_async got per=%0d hi=%0d flags=%b exp 0/0/0000", period_cnt, high_cnt,
                        {meas_valid, meas_ovf, stuck, stuck_level});
    end
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    clear_logs();
    drive(1'b0, 20);
    tests++;
    if (period_cnt !== 16'd0 || m_cyc.size() !== 0) begin
      fails++; $display("FAIL rst_release got per=%0d meas=%0d exp 0/0", period_cnt, m_cyc.size());
    end
    repeat (3) pwm_period($urandom_range(200, 40), $urandom_range(30, 5));
    drive(1'b1, 5);
    drive(1'b0, 10);
    model_expect(SYNC, 16);
    tests++;
    if (m_cyc.size() !== e_cyc.size() || e_cyc.size() !== 3) begin
      fails++; $display("FAIL rst_post_count got %0d exp %0d", m_cyc.size(), e_cyc.size());
    end
    for (int i = 0; i < e_cyc.size() && i < m_cyc.size(); i++) begin
      tests++;
      if (m_cyc[i] !== e_cyc[i] || m_per[i] !== e_per[i] || m_hi[i] !== e_hi[i] || m_ovf[i] !== e_ovf[i]) begin
        fails++;
        $display("FAIL rst_post_meas[%0d] got cyc=%0d per=%0d hi=%0d exp cyc=%0d per=%0d hi=%0d",
                 i, m_cyc[i], m_per[i], m_hi[i], e_cyc[i], e_per[i], e_hi[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_duty_sweep();
    test_random();
    test_stuck(1'b0);
    test_stuck(1'b1);
    test_saturation();
    test_enable_drop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
